// File: rtl/quick_uart_rx_fifo.sv
// quick_uart_rx_fifo
//   Elastic buffer behind a UART receiver. It stores received words in a
//   first-word-fall-through FIFO. The receiver is never stalled. When the
//   FIFO is full, the incoming word is discarded. The loss is then marked
//   on the next word that gets stored.
//
// Ports
//   clk_i             system clock
//   rst_i             synchronous active-high reset
//   in_valid_i        receiver has a word (push)
//   in_ready_o        constant 1
//   in_data_i         received word
//   in_dropped_i      receiver lost word(s) before this one
//   out_valid_o       FIFO non-empty; head word outputs are valid
//   out_ready_i       sink accepts the head word (pop)
//   out_data_o        head word
//   out_dropped_o     word(s) were lost immediately before the head word
//   count_o           number of stored words
//   overflow_count_o  saturating count of words discarded on overflow
module quick_uart_rx_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OVF_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_BITS-1:0]         in_data_i,
    input  logic                         in_dropped_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_BITS-1:0]         out_data_o,
    output logic                         out_dropped_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [OVF_WIDTH-1:0]         overflow_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Each entry is {dropped_flag, data}.
    logic [DATA_BITS:0] mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q = '0;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q = '0;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [CNT_W-1:0]     count_q = '0;
    logic [CNT_W-1:0]     count_d;
    logic                 drop_pending_q = 1'b0;
    logic                 drop_pending_d;
    logic [OVF_WIDTH-1:0] ovf_q = '0;
    logic [OVF_WIDTH-1:0] ovf_d;

    logic pop;
    logic push_ok;
    logic push_rej;

    assign in_ready_o = 1'b1;

    assign out_valid_o   = (count_q != '0);
    assign out_data_o    = mem_q[rd_ptr_q][DATA_BITS-1:0];
    assign out_dropped_o = mem_q[rd_ptr_q][DATA_BITS];
    assign count_o          = count_q;
    assign overflow_count_o = ovf_q;

    assign pop      = out_valid_o && out_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = in_valid_i && ((count_q != FULL_CNT) || pop);
    assign push_rej = in_valid_i && !push_ok;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        drop_pending_d = drop_pending_q;
        ovf_d          = ovf_q;

        if (push_ok) begin
            wr_ptr_d       = wr_ptr_q + 1'b1;
            drop_pending_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (push_rej) begin
            drop_pending_d = 1'b1;
            if (ovf_q != '1) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            drop_pending_q <= 1'b0;
            ovf_q          <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            drop_pending_q <= drop_pending_d;
            ovf_q          <= ovf_d;
        end
    end

    // Storage has no reset; contents are meaningless while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= {in_dropped_i | drop_pending_q, in_data_i};
        end
    end

endmodule

// File: tb/tb_quick_uart_rx_fifo.sv
// tb_quick_uart_rx_fifo
//   Checks quick_uart_rx_fifo (DEPTH=4, OVF_WIDTH=2) against a queue-based
//   reference model. The stimulus is a set of directed sequences followed by
//   random traffic.
module tb_quick_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned OVFMAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_dropped = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_dropped;
    logic [2:0] count;
    logic [1:0] ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queue of {dropped, data}.
    logic [8:0]  mq[$];
    bit          m_pend = 0;
    int unsigned m_ovf  = 0;

    always #5 clk = ~clk;

    quick_uart_rx_fifo #(
        .DATA_BITS (8),
        .DEPTH     (DEPTH),
        .OVF_WIDTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_data_i        (in_data),
        .in_dropped_i     (in_dropped),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_data_o       (out_data),
        .out_dropped_o    (out_dropped),
        .count_o          (count),
        .overflow_count_o (ovf_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle. Outputs are compared against the model at the negedge,
    // then the model advances by the same rules at the posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit dr, input bit rdy, input bit rs);
        bit pop;
        in_valid   = v;
        in_data    = d;
        in_dropped = dr;
        out_ready  = rdy;
        rst        = rs;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'd1);
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("ovf_count", 32'(ovf_count), 32'(m_ovf));
        if (mq.size() != 0) begin
            check_eq("out_data", 32'(out_data), 32'(mq[0][7:0]));
            check_eq("out_dropped", 32'(out_dropped), 32'(mq[0][8]));
        end
        pop = (mq.size() != 0) && rdy;
        if (rs) begin
            mq.delete();
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({dr | m_pend, d});
                    m_pend = 0;
                end else begin
                    m_pend = 1;
                    if (m_ovf < OVFMAX) m_ovf++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Three pushes with the sink stalled, then drain
        step(1, 8'h41, 0, 0, 0);
        step(1, 8'h42, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0);
        check_eq("cnt3", 32'(count), 32'd3);
        check_eq("head41", 32'(out_data), 32'h41);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check_eq("drained_valid", 32'(out_valid), 32'd0);
        step(0, 8'h00, 0, 0, 0);

        // Overflow: fill, two rejected, drain, push after the gap
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        step(1, 8'h14, 0, 0, 0);
        step(1, 8'h15, 0, 0, 0);
        check_eq("ovf2", 32'(ovf_count), 32'd2);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 0);
        step(1, 8'h16, 0, 0, 0);
        check_eq("gap_flag", 32'(out_dropped), 32'd1);
        check_eq("gap_data", 32'(out_data), 32'h16);
        step(0, 8'h00, 0, 1, 0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        step(1, 8'h20, 0, 1, 0);
        check_eq("full_cnt", 32'(count), 32'd4);
        check_eq("full_ovf", 32'(ovf_count), 32'd2);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 0);

        // Receiver-reported drop, followed by a clean word
        step(1, 8'h55, 1, 0, 0);
        check_eq("rx_drop", 32'(out_dropped), 32'd1);
        step(1, 8'h56, 0, 1, 0);
        check_eq("clean_after", 32'(out_dropped), 32'd0);
        step(0, 8'h00, 0, 1, 0);

        // Saturation, then reset with a push presented in the reset cycle
        for (int i = 0; i < 9; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        check_eq("ovf_sat", 32'(ovf_count), 32'd3);
        step(1, 8'h77, 0, 0, 1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ovf", 32'(ovf_count), 32'd0);
        step(0, 8'h00, 0, 0, 0);

        // Random traffic with phases of heavy and light draining
        for (int i = 0; i < 600; i++) begin
            int unsigned rp;
            rp = ((i / 50) % 2 == 0) ? 25 : 75;
            step($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 10,
                 $urandom_range(99) < rp, $urandom_range(199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
